// File: rtl/sccb_slave_rx.sv
// SCCB write receiver: oversamples SCL/SDA, decodes start/stop, shifts in
// ID/address/data and emits a one-cycle strobe for every complete, ID-matched write.
`timescale 1ns/1ps
module sccb_slave_rx #(
  parameter logic [6:0] c_id      = 7'h21,
  parameter bit         c_ack_en  = 1'b0,
  parameter int         c_nb_sync = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk_in,
  input  logic       sdat_in,
  output logic       sdat_oe,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {
    IDLE_ST,
    RX_BYTE_ST,
    DNTC_ST,
    WAIT_STOP_ST,
    IGNORE_ST
  } state_t;

  logic [c_nb_sync-1:0] scl_sync_q, sda_sync_q;
  logic                 scl_prev_q, sda_prev_q;
  logic                 scl_s, sda_s;
  logic                 scl_rise, scl_fall, start_det, stop_det;

  state_t      state_q, state_d;
  logic [2:0]  cnt_8bits_q, cnt_8bits_d;
  logic [1:0]  cnt_phases_q, cnt_phases_d;
  logic [6:0]  shift_q, shift_d;
  logic        match_q, match_d;
  logic        rise_seen_q, rise_seen_d;
  logic        sdat_oe_q, sdat_oe_d;
  logic [7:0]  addr_hold_q, addr_hold_d;
  logic [7:0]  data_hold_q, data_hold_d;
  logic [7:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        wr_valid_q, wr_valid_d;
  logic        err_q, err_d;
  logic [7:0]  byte_nxt;

  assign scl_s     = scl_sync_q[c_nb_sync-1];
  assign sda_s     = sda_sync_q[c_nb_sync-1];
  assign scl_rise  =  scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s &  scl_prev_q;
  assign start_det =  scl_s & ~sda_s &  sda_prev_q;
  assign stop_det  =  scl_s &  sda_s & ~sda_prev_q;

  // Only 7 bits are stored; the 8th bit joins combinationally on the final sample.
  assign byte_nxt = {shift_q, sda_s};

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d      = state_q;
    cnt_8bits_d  = cnt_8bits_q;
    cnt_phases_d = cnt_phases_q;
    shift_d      = shift_q;
    match_d      = match_q;
    rise_seen_d  = rise_seen_q;
    sdat_oe_d    = sdat_oe_q;
    addr_hold_d  = addr_hold_q;
    data_hold_d  = data_hold_q;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    wr_valid_d   = 1'b0;
    err_d        = 1'b0;

    if (start_det) begin
      state_d      = RX_BYTE_ST;
      cnt_8bits_d  = 3'd7;
      cnt_phases_d = 2'd0;
      shift_d      = '0;
      match_d      = 1'b0;
      rise_seen_d  = 1'b0;
      sdat_oe_d    = 1'b0;
    end else if (stop_det) begin
      state_d     = IDLE_ST;
      sdat_oe_d   = 1'b0;
      rise_seen_d = 1'b0;
      case (state_q)
        RX_BYTE_ST, DNTC_ST: err_d = 1'b1;
        WAIT_STOP_ST: begin
          wr_valid_d = 1'b1;
          wr_addr_d  = addr_hold_q;
          wr_data_d  = data_hold_q;
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        RX_BYTE_ST: begin
          if (scl_rise) begin
            shift_d     = byte_nxt[6:0];
            cnt_8bits_d = cnt_8bits_q - 3'd1;
            if (cnt_8bits_q == 3'd0) begin
              state_d     = DNTC_ST;
              rise_seen_d = 1'b0;
              case (cnt_phases_q)
                2'd0:    match_d     = (byte_nxt[7:1] == c_id) && !byte_nxt[0];
                2'd1:    addr_hold_d = byte_nxt;
                default: data_hold_d = byte_nxt;
              endcase
            end
          end
        end
        DNTC_ST: begin
          if (scl_rise) rise_seen_d = 1'b1;
          if (scl_fall) begin
            if (!rise_seen_q) begin
              sdat_oe_d = c_ack_en && match_q;
            end else begin
              sdat_oe_d   = 1'b0;
              rise_seen_d = 1'b0;
              cnt_8bits_d = 3'd7;
              if (!match_q)                 state_d = IGNORE_ST;
              else if (cnt_phases_q == 2'd2) state_d = WAIT_STOP_ST;
              else begin
                state_d      = RX_BYTE_ST;
                cnt_phases_d = cnt_phases_q + 2'd1;
              end
            end
          end
        end
        WAIT_STOP_ST: begin
          // The first SCL rise here is the stop setup; a second one means more data.
          if (scl_rise) begin
            if (rise_seen_q) begin
              err_d       = 1'b1;
              state_d     = IGNORE_ST;
              rise_seen_d = 1'b0;
            end else begin
              rise_seen_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= IDLE_ST;
      cnt_8bits_q  <= 3'd7;
      cnt_phases_q <= 2'd0;
      shift_q      <= '0;
      match_q      <= 1'b0;
      rise_seen_q  <= 1'b0;
      sdat_oe_q    <= 1'b0;
      addr_hold_q  <= '0;
      data_hold_q  <= '0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      wr_valid_q   <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      scl_sync_q   <= {scl_sync_q[c_nb_sync-2:0], sclk_in};
      sda_sync_q   <= {sda_sync_q[c_nb_sync-2:0], sdat_in};
      scl_prev_q   <= scl_s;
      sda_prev_q   <= sda_s;
      state_q      <= state_d;
      cnt_8bits_q  <= cnt_8bits_d;
      cnt_phases_q <= cnt_phases_d;
      shift_q      <= shift_d;
      match_q      <= match_d;
      rise_seen_q  <= rise_seen_d;
      sdat_oe_q    <= sdat_oe_d;
      addr_hold_q  <= addr_hold_d;
      data_hold_q  <= data_hold_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      wr_valid_q   <= wr_valid_d;
      err_q        <= err_d;
    end
  end

  assign sdat_oe  = sdat_oe_q;
  assign wr_valid = wr_valid_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign err      = err_q;
  assign busy     = (state_q != IDLE_ST);

endmodule

// File: tb/tb_sccb_slave_rx.sv
// Directed bench for sccb_slave_rx: a bit-banged SCCB master on a wired-AND bus
// shared by a non-acking slave (u_dut) and an acking slave (u_ack).
`timescale 1ns/1ps
module tb_sccb_slave_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       oe0, valid0, busy0, err0;
  logic [7:0] addr0, data0;
  logic       oe1, valid1, busy1, err1;
  logic [7:0] addr1, data1;

  int q_clk = 20;
  int n_pass = 0;
  int n_total = 0;

  int n_valid_rise = 0, n_valid_cyc = 0, n_err_rise = 0, n_err_cyc = 0;
  int n_busy_fall = 0, n_oe0_cyc = 0, n_oe1_cyc = 0, n_oe1_rise = 0;
  logic valid_p = 1'b0, err_p = 1'b0, busy_p = 1'b0, oe1_p = 1'b0;

  always #5 clk = ~clk;

  assign sda_bus = sda_m & ~oe0 & ~oe1;

  sccb_slave_rx #(.c_id(7'h21), .c_ack_en(1'b0), .c_nb_sync(2)) u_dut (
    .clk(clk), .rst(rst), .sclk_in(scl_m), .sdat_in(sda_bus),
    .sdat_oe(oe0), .wr_valid(valid0), .wr_addr(addr0), .wr_data(data0),
    .busy(busy0), .err(err0)
  );

  sccb_slave_rx #(.c_id(7'h21), .c_ack_en(1'b1), .c_nb_sync(2)) u_ack (
    .clk(clk), .rst(rst), .sclk_in(scl_m), .sdat_in(sda_bus),
    .sdat_oe(oe1), .wr_valid(valid1), .wr_addr(addr1), .wr_data(data1),
    .busy(busy1), .err(err1)
  );

  always @(negedge clk) begin
    if (valid0) n_valid_cyc++;
    if (valid0 && !valid_p) n_valid_rise++;
    if (err0) n_err_cyc++;
    if (err0 && !err_p) n_err_rise++;
    if (!busy0 && busy_p) n_busy_fall++;
    if (oe0) n_oe0_cyc++;
    if (oe1) n_oe1_cyc++;
    if (oe1 && !oe1_p) n_oe1_rise++;
    valid_p = valid0;
    err_p   = err0;
    busy_p  = busy0;
    oe1_p   = oe1;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish within 5 ms");
    $fatal(1);
  end

  // ---------------- bus master ----------------
  task automatic wait_q(input int n);
    repeat (n * q_clk) @(negedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; scl_m = 1'b1; wait_q(1);
    sda_m = 1'b0; wait_q(1);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic bus_rep_start();
    sda_m = 1'b1; wait_q(1);
    scl_m = 1'b1; wait_q(1);
    sda_m = 1'b0; wait_q(1);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic bus_bit(input logic b);
    sda_m = b; wait_q(1);
    scl_m = 1'b1; wait_q(2);
    scl_m = 1'b0; wait_q(1);
  endtask

  // Sends a byte plus the released 9th bit; ack_o is the acking slave's oe mid-9th-high.
  task automatic bus_byte(input logic [7:0] b, output logic ack_o);
    for (int i = 7; i >= 0; i--) bus_bit(b[i]);
    sda_m = 1'b1; wait_q(1);
    scl_m = 1'b1; wait_q(1);
    ack_o = oe1;
    wait_q(1);
    scl_m = 1'b0; wait_q(1);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_q(1);
    scl_m = 1'b1; wait_q(1);
    sda_m = 1'b1; wait_q(1);
  endtask

  task automatic bus_frame(input logic [7:0] id, input logic [7:0] a, input logic [7:0] d);
    logic ack;
    bus_start();
    bus_byte(id, ack);
    bus_byte(a, ack);
    bus_byte(d, ack);
    bus_stop();
    wait_q(1);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (4) @(negedge clk);
    n_total++; if (valid0 !== 1'b0) $display("FAIL reset_wr_valid: got %b want 0", valid0); else n_pass++;
    n_total++; if (addr0 !== 8'h00) $display("FAIL reset_wr_addr: got %h want 00", addr0); else n_pass++;
    n_total++; if (data0 !== 8'h00) $display("FAIL reset_wr_data: got %h want 00", data0); else n_pass++;
    n_total++; if (busy0 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy0); else n_pass++;
    n_total++; if (err0 !== 1'b0) $display("FAIL reset_err: got %b want 0", err0); else n_pass++;
    n_total++; if (oe0 !== 1'b0 || oe1 !== 1'b0) $display("FAIL reset_sdat_oe: got %b/%b want 0/0", oe0, oe1); else n_pass++;
    rst = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_basic_write();
    int v0, vc0, e0, bf0, o0;
    logic ack;
    q_clk = 65;
    v0 = n_valid_rise; vc0 = n_valid_cyc; e0 = n_err_cyc; o0 = n_oe0_cyc;
    n_total++; if (busy0 !== 1'b0) $display("FAIL basic_busy_before: got %b want 0", busy0); else n_pass++;
    bus_start();
    bf0 = n_busy_fall;
    n_total++; if (busy0 !== 1'b1) $display("FAIL basic_busy_after_start: got %b want 1", busy0); else n_pass++;
    bus_byte(8'h42, ack);
    bus_byte(8'h12, ack);
    bus_byte(8'h80, ack);
    n_total++; if (busy0 !== 1'b1) $display("FAIL basic_busy_before_stop: got %b want 1", busy0); else n_pass++;
    n_total++; if (n_busy_fall != bf0) $display("FAIL basic_busy_gap: got %0d drops want 0", n_busy_fall - bf0); else n_pass++;
    bus_stop();
    wait_q(1);
    n_total++; if (busy0 !== 1'b0) $display("FAIL basic_busy_after_stop: got %b want 0", busy0); else n_pass++;
    n_total++; if (n_valid_rise - v0 != 1) $display("FAIL basic_valid_pulses: got %0d want 1", n_valid_rise - v0); else n_pass++;
    n_total++; if (n_valid_cyc - vc0 != 1) $display("FAIL basic_valid_width: got %0d cycles want 1", n_valid_cyc - vc0); else n_pass++;
    n_total++; if (addr0 !== 8'h12) $display("FAIL basic_wr_addr: got %h want 12", addr0); else n_pass++;
    n_total++; if (data0 !== 8'h80) $display("FAIL basic_wr_data: got %h want 80", data0); else n_pass++;
    n_total++; if (n_err_cyc != e0) $display("FAIL basic_err: got %0d cycles want 0", n_err_cyc - e0); else n_pass++;
    n_total++; if (n_oe0_cyc != o0) $display("FAIL basic_no_ack_oe: got %0d cycles want 0", n_oe0_cyc - o0); else n_pass++;
    q_clk = 20;
  endtask

  task automatic test_no_match(input logic [7:0] id);
    int v0, e0, o0, o1;
    v0 = n_valid_rise; e0 = n_err_cyc; o0 = n_oe0_cyc; o1 = n_oe1_cyc;
    bus_frame(id, 8'h3A, 8'h04);
    n_total++; if (n_valid_rise != v0) $display("FAIL nomatch_%h_valid: got %0d want 0", id, n_valid_rise - v0); else n_pass++;
    n_total++; if (n_err_cyc != e0) $display("FAIL nomatch_%h_err: got %0d want 0", id, n_err_cyc - e0); else n_pass++;
    n_total++; if (n_oe0_cyc != o0 || n_oe1_cyc != o1) $display("FAIL nomatch_%h_oe: got %0d/%0d cycles want 0/0", id, n_oe0_cyc - o0, n_oe1_cyc - o1); else n_pass++;
    n_total++; if (addr0 !== 8'h12 || data0 !== 8'h80) $display("FAIL nomatch_%h_hold: got %h/%h want 12/80", id, addr0, data0); else n_pass++;
    n_total++; if (busy0 !== 1'b0) $display("FAIL nomatch_%h_busy: got %b want 0", id, busy0); else n_pass++;
  endtask

  task automatic test_abort();
    int v0, er0, ec0;
    logic ack;
    v0 = n_valid_rise; er0 = n_err_rise; ec0 = n_err_cyc;
    bus_start();
    bus_byte(8'h42, ack);
    bus_byte(8'h11, ack);
    bus_stop();
    wait_q(1);
    n_total++; if (n_err_rise - er0 != 1) $display("FAIL abort_err_pulses: got %0d want 1", n_err_rise - er0); else n_pass++;
    n_total++; if (n_err_cyc - ec0 != 1) $display("FAIL abort_err_width: got %0d cycles want 1", n_err_cyc - ec0); else n_pass++;
    n_total++; if (n_valid_rise != v0) $display("FAIL abort_valid: got %0d want 0", n_valid_rise - v0); else n_pass++;
    n_total++; if (addr0 !== 8'h12 || data0 !== 8'h80) $display("FAIL abort_hold: got %h/%h want 12/80", addr0, data0); else n_pass++;
    n_total++; if (busy0 !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy0); else n_pass++;
  endtask

  task automatic test_ack();
    int r0, c0, e0;
    logic a_id, a_addr, a_data;
    r0 = n_oe1_rise; c0 = n_oe1_cyc; e0 = n_err_cyc;
    bus_start();
    bus_byte(8'h42, a_id);
    bus_byte(8'h40, a_addr);
    bus_byte(8'hD0, a_data);
    bus_stop();
    wait_q(1);
    n_total++; if ({a_id, a_addr, a_data} !== 3'b111) $display("FAIL ack_in_9th_bit: got %b want 111", {a_id, a_addr, a_data}); else n_pass++;
    n_total++; if (n_oe1_rise - r0 != 3) $display("FAIL ack_windows: got %0d want 3", n_oe1_rise - r0); else n_pass++;
    // Each window spans fall-after-bit-0 to fall-after-9th-bit: 4 quarter periods.
    n_total++; if (n_oe1_cyc - c0 != 12 * q_clk) $display("FAIL ack_oe_cycles: got %0d want %0d", n_oe1_cyc - c0, 12 * q_clk); else n_pass++;
    n_total++; if (oe1 !== 1'b0) $display("FAIL ack_oe_released: got %b want 0", oe1); else n_pass++;
    n_total++; if (addr1 !== 8'h40 || data1 !== 8'hD0) $display("FAIL ack_wr: got %h/%h want 40/D0", addr1, data1); else n_pass++;
    n_total++; if (n_err_cyc != e0) $display("FAIL ack_err: got %0d want 0", n_err_cyc - e0); else n_pass++;
  endtask

  task automatic test_repeated_start();
    int v0, e0;
    logic ack;
    v0 = n_valid_rise; e0 = n_err_cyc;
    bus_start();
    bus_byte(8'h42, ack);
    bus_rep_start();
    bus_byte(8'h42, ack);
    bus_byte(8'h8C, ack);
    bus_byte(8'h00, ack);
    bus_stop();
    wait_q(1);
    n_total++; if (n_valid_rise - v0 != 1) $display("FAIL rstart_valid: got %0d want 1", n_valid_rise - v0); else n_pass++;
    n_total++; if (addr0 !== 8'h8C || data0 !== 8'h00) $display("FAIL rstart_wr: got %h/%h want 8C/00", addr0, data0); else n_pass++;
    n_total++; if (n_err_cyc != e0) $display("FAIL rstart_err: got %0d want 0", n_err_cyc - e0); else n_pass++;
  endtask

  task automatic test_async_reset();
    int v0, e0;
    logic ack;
    bus_start();
    bus_byte(8'h42, ack);
    for (int i = 0; i < 4; i++) bus_bit(1'b0);
    n_total++; if (busy0 !== 1'b1) $display("FAIL areset_busy_before: got %b want 1", busy0); else n_pass++;
    #2 rst = 1'b0;
    #1;
    n_total++; if ({busy0, valid0, err0, oe0} !== 4'b0000) $display("FAIL areset_ctrl: got %b want 0000", {busy0, valid0, err0, oe0}); else n_pass++;
    n_total++; if (addr0 !== 8'h00 || data0 !== 8'h00) $display("FAIL areset_wr: got %h/%h want 00/00", addr0, data0); else n_pass++;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    e0 = n_err_cyc;
    bus_stop();
    wait_q(1);
    n_total++; if (n_err_cyc != e0) $display("FAIL areset_stray_stop_err: got %0d want 0", n_err_cyc - e0); else n_pass++;
    v0 = n_valid_rise;
    bus_frame(8'h42, 8'h01, 8'h55);
    n_total++; if (n_valid_rise - v0 != 1) $display("FAIL areset_valid: got %0d want 1", n_valid_rise - v0); else n_pass++;
    n_total++; if (addr0 !== 8'h01 || data0 !== 8'h55) $display("FAIL areset_wr_after: got %h/%h want 01/55", addr0, data0); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_no_match(8'h60);
    test_no_match(8'h43);
    test_abort();
    test_ack();
    test_repeated_start();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
